// File: rtl/risc_multicycle_ctrl_fsm_pkg.sv
// Shared definitions for the multi-cycle RISC-V control sequencer.
// Holds opcodes, the state encoding, ALU control codes and datapath mux select codes.
// Pure definitions only: no logic, no latency, no handshake.
package risc_ctrl_pkg;

  localparam int XLEN      = 32;
  localparam int ALUCTRL_W = 3;

  // Supported major opcodes
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_RTYPE  = 7'b0110011;
  localparam logic [6:0] OP_ITYPE  = 7'b0010011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;

  typedef enum logic [3:0] {
    S_RST, S_FETCH, S_DECODE, S_MEMADR, S_MEMREAD, S_MEMWB,
    S_MEMWRITE, S_EXEC_R, S_EXEC_I, S_ALUWB, S_BRANCH
  } state_t;

  // What the sequencer asks of the ALU decoder
  typedef enum logic [1:0] {ALUOP_ADD, ALUOP_SUB, ALUOP_FUNCT} alu_op_t;

  // ALU control codes, identical to the single-cycle control unit
  localparam logic [ALUCTRL_W-1:0] ALU_ADD = 3'b000;
  localparam logic [ALUCTRL_W-1:0] ALU_SUB = 3'b010;
  localparam logic [ALUCTRL_W-1:0] ALU_SLL = 3'b001;
  localparam logic [ALUCTRL_W-1:0] ALU_XOR = 3'b100;
  localparam logic [ALUCTRL_W-1:0] ALU_SRL = 3'b101;
  localparam logic [ALUCTRL_W-1:0] ALU_OR  = 3'b110;
  localparam logic [ALUCTRL_W-1:0] ALU_AND = 3'b111;

  // Datapath mux selects
  localparam logic [1:0] IMM_I = 2'b00, IMM_S = 2'b01, IMM_B = 2'b10;
  localparam logic [1:0] SRCA_PC = 2'b00, SRCA_OLDPC = 2'b01, SRCA_RS1 = 2'b10;
  localparam logic [1:0] SRCB_RS2 = 2'b00, SRCB_IMM = 2'b01, SRCB_FOUR = 2'b10;
  localparam logic [1:0] RES_ALUOUT = 2'b00, RES_MEM = 2'b01, RES_ALU = 2'b10;

endpackage

// File: rtl/risc_multicycle_ctrl_fsm_if.sv
// Control bundle between the multi-cycle sequencer and its datapath/memory.
// master = sequencer (drives strobes and selects), slave = datapath side.
// Memory handshake: mem_req held with stable address until mem_ready.
interface risc_multicycle_ctrl_fsm_if;
  logic [31:0] instr_32;
  logic        ZF;
  logic        SF;
  logic        mem_ready;
  logic        mem_req;
  logic        mem_write;
  logic        adr_src;
  logic        ir_write;
  logic        pc_write;
  logic        reg_write;
  logic [1:0]  imm_src_2;
  logic [1:0]  alu_src_a_2;
  logic [1:0]  alu_src_b_2;
  logic [2:0]  alu_control_3;
  logic [1:0]  result_src_2;
  logic        illegal_instr;

  modport master (
    input  instr_32, ZF, SF, mem_ready,
    output mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
           imm_src_2, alu_src_a_2, alu_src_b_2, alu_control_3,
           result_src_2, illegal_instr
  );

  modport slave (
    output instr_32, ZF, SF, mem_ready,
    input  mem_req, mem_write, adr_src, ir_write, pc_write, reg_write,
           imm_src_2, alu_src_a_2, alu_src_b_2, alu_control_3,
           result_src_2, illegal_instr
  );
endinterface

// File: rtl/risc_multicycle_ctrl_fsm_alu_dec.sv
// ALU control decode from sequencer request, funct3, op[5] and funct7 bit 5.
// Purely combinational, zero latency.
// No handshake; output follows inputs.
module risc_alu_dec
  import risc_ctrl_pkg::*;
(
  input  alu_op_t               alu_op_i,
  input  logic [2:0]            funct3_i,
  input  logic                  op5_i,
  input  logic                  funct7b5_i,
  output logic [ALUCTRL_W-1:0]  alu_control_o
);

  // funct3 map; only register-register ops with funct7b5 set subtract
  always_comb begin
    alu_control_o = ALU_ADD;
    case (alu_op_i)
      ALUOP_SUB:   alu_control_o = ALU_SUB;
      ALUOP_FUNCT: begin
        case (funct3_i)
          3'b000:  alu_control_o = (op5_i & funct7b5_i) ? ALU_SUB : ALU_ADD;
          3'b001:  alu_control_o = ALU_SLL;
          3'b100:  alu_control_o = ALU_XOR;
          3'b101:  alu_control_o = ALU_SRL;
          3'b110:  alu_control_o = ALU_OR;
          3'b111:  alu_control_o = ALU_AND;
          default: alu_control_o = ALU_ADD;
        endcase
      end
      default:     alu_control_o = ALU_ADD;
    endcase
  end

endmodule

// File: rtl/risc_multicycle_ctrl_fsm.sv
// Multi-cycle RISC-V sequencer: fetch/decode/execute/memory/writeback control.
// 3-5 cycles per instruction plus memory wait cycles; outputs decode the state register.
// Memory waits hold mem_req and address until mem_ready. Optional macro: RISC_PERF_CNT_EN.
module risc_multicycle_ctrl_fsm
  import risc_ctrl_pkg::*;
(
  input  logic                          clk,
  input  logic                          rst_n,
  risc_multicycle_ctrl_fsm_if.master    bus
`ifdef RISC_PERF_CNT_EN
  ,
  output logic [31:0]                   instret_32
`endif
);

  state_t      state_q, state_d;
  alu_op_t     alu_op;
  logic [6:0]  op;
  logic [2:0]  funct3;
  logic        legal_op;
  logic        unused_instr_bits;

  assign op       = bus.instr_32[6:0];
  assign funct3   = bus.instr_32[14:12];
  assign legal_op = (op == OP_LOAD) || (op == OP_STORE) || (op == OP_RTYPE) ||
                    (op == OP_ITYPE) || (op == OP_BRANCH);
  assign unused_instr_bits = ^{bus.instr_32[31], bus.instr_32[29:15], bus.instr_32[11:7]};

  risc_alu_dec u_alu_dec (
    .alu_op_i      (alu_op),
    .funct3_i      (funct3),
    .op5_i         (op[5]),
    .funct7b5_i    (bus.instr_32[30]),
    .alu_control_o (bus.alu_control_3)
  );

  // State register; reset aborts any in-flight instruction
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_RST;
    else        state_q <= state_d;
  end

  // Moore output decode and next state; fetch/memory strobes gated by mem_ready
  always_comb begin
    state_d           = state_q;
    alu_op            = ALUOP_ADD;
    bus.mem_req       = 1'b0;
    bus.mem_write     = 1'b0;
    bus.adr_src       = 1'b0;
    bus.ir_write      = 1'b0;
    bus.pc_write      = 1'b0;
    bus.reg_write     = 1'b0;
    bus.imm_src_2     = IMM_I;
    bus.alu_src_a_2   = SRCA_PC;
    bus.alu_src_b_2   = SRCB_RS2;
    bus.result_src_2  = RES_ALUOUT;
    bus.illegal_instr = 1'b0;
    case (state_q)
      S_RST: state_d = S_FETCH;
      S_FETCH: begin
        bus.mem_req      = 1'b1;
        bus.alu_src_b_2  = SRCB_FOUR;
        bus.result_src_2 = RES_ALU;
        if (bus.mem_ready) begin
          bus.ir_write = 1'b1;
          bus.pc_write = 1'b1;
          state_d      = S_DECODE;
        end
      end
      S_DECODE: begin
        bus.alu_src_a_2 = SRCA_OLDPC;
        bus.alu_src_b_2 = SRCB_IMM;
        bus.imm_src_2   = IMM_B;
        case (op)
          OP_LOAD, OP_STORE: state_d = S_MEMADR;
          OP_RTYPE:          state_d = S_EXEC_R;
          OP_ITYPE:          state_d = S_EXEC_I;
          OP_BRANCH:         state_d = S_BRANCH;
          default: begin
            bus.illegal_instr = 1'b1;
            state_d           = S_FETCH;
          end
        endcase
      end
      S_MEMADR: begin
        bus.alu_src_a_2 = SRCA_RS1;
        bus.alu_src_b_2 = SRCB_IMM;
        bus.imm_src_2   = op[5] ? IMM_S : IMM_I;
        state_d         = op[5] ? S_MEMWRITE : S_MEMREAD;
      end
      S_MEMREAD: begin
        bus.mem_req = 1'b1;
        bus.adr_src = 1'b1;
        if (bus.mem_ready) state_d = S_MEMWB;
      end
      S_MEMWB: begin
        bus.result_src_2 = RES_MEM;
        bus.reg_write    = 1'b1;
        state_d          = S_FETCH;
      end
      S_MEMWRITE: begin
        bus.mem_req   = 1'b1;
        bus.mem_write = 1'b1;
        bus.adr_src   = 1'b1;
        if (bus.mem_ready) state_d = S_FETCH;
      end
      S_EXEC_R, S_EXEC_I: begin
        bus.alu_src_a_2 = SRCA_RS1;
        bus.alu_src_b_2 = (state_q == S_EXEC_I) ? SRCB_IMM : SRCB_RS2;
        alu_op          = ALUOP_FUNCT;
        state_d         = S_ALUWB;
      end
      S_ALUWB: begin
        bus.reg_write = 1'b1;
        state_d       = S_FETCH;
      end
      S_BRANCH: begin
        bus.alu_src_a_2 = SRCA_RS1;
        alu_op          = ALUOP_SUB;
        case (funct3)
          3'b000:  bus.pc_write = bus.ZF;
          3'b001:  bus.pc_write = ~bus.ZF;
          3'b100:  bus.pc_write = bus.SF;
          default: bus.pc_write = 1'b0;
        endcase
        state_d = S_FETCH;
      end
      default: state_d = S_RST;
    endcase
  end

`ifdef RISC_PERF_CNT_EN
  logic        retire;
  logic [31:0] instret_q;

  assign retire = (state_q == S_MEMWB) || (state_q == S_ALUWB) || (state_q == S_BRANCH) ||
                  ((state_q == S_MEMWRITE) && bus.mem_ready);
  assign instret_32 = instret_q;

  // Retired-instruction counter; wraps naturally at 2^32
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      instret_q <= '0;
    else if (retire) instret_q <= instret_q + 32'd1;
  end
`endif

endmodule

// File: tb/tb_risc_multicycle_ctrl_fsm.sv
// Directed bench for the multi-cycle sequencer.
// Walks hand-decoded instructions state by state, comparing every control output.
// Inputs driven 1 time unit after the rising edge, outputs sampled on the falling edge.
module tb_risc_multicycle_ctrl_fsm;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  risc_multicycle_ctrl_fsm_if bus ();

`ifdef RISC_PERF_CNT_EN
  logic [31:0] instret_32;
  risc_multicycle_ctrl_fsm dut (.clk(clk), .rst_n(rst_n), .bus(bus), .instret_32(instret_32));
`else
  risc_multicycle_ctrl_fsm dut (.clk(clk), .rst_n(rst_n), .bus(bus));
`endif

  logic [17:0] outs;
  assign outs = {bus.mem_req, bus.mem_write, bus.adr_src, bus.ir_write, bus.pc_write,
                 bus.reg_write, bus.imm_src_2, bus.alu_src_a_2, bus.alu_src_b_2,
                 bus.alu_control_3, bus.result_src_2, bus.illegal_instr};

  // Expected output vector in the same field order as outs
  function automatic logic [17:0] mk(input logic rq, input logic wr, input logic as,
                                     input logic irw, input logic pcw, input logic rw,
                                     input logic [1:0] imm, input logic [1:0] sa,
                                     input logic [1:0] sb, input logic [2:0] alu,
                                     input logic [1:0] res, input logic ill);
    return {rq, wr, as, irw, pcw, rw, imm, sa, sb, alu, res, ill};
  endfunction

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  logic [17:0] F_RDY, F_WAIT, DEC, DEC_ILL, ALUWB;

  // Sample the current state's outputs, then advance one clock
  task automatic step(input string tag, input logic [17:0] exp);
    @(negedge clk);
    check(tag, {14'b0, outs}, {14'b0, exp});
    @(posedge clk);
    #1;
  endtask

  // FETCH with memory ready; IR takes the new word on the same edge
  task automatic fetch(input string tag, input logic [31:0] ins);
    bus.mem_ready = 1'b1;
    step(tag, F_RDY);
    bus.instr_32 = ins;
  endtask

  task automatic exec_rr(input string tag, input logic [31:0] ins, input logic isi,
                         input logic [2:0] alu);
    fetch({tag, "_fetch"}, ins);
    step({tag, "_dec"}, DEC);
    step({tag, "_exec"}, mk(0,0,0,0,0,0, 2'b00, 2'b10, isi ? 2'b01 : 2'b00, alu, 2'b00, 0));
    step({tag, "_wb"}, ALUWB);
  endtask

  task automatic branch(input string tag, input logic [31:0] ins, input logic zf,
                        input logic sf, input logic pcw);
    fetch({tag, "_fetch"}, ins);
    bus.ZF = zf;
    bus.SF = sf;
    step({tag, "_dec"}, DEC);
    step({tag, "_br"}, mk(0,0,0,0,pcw,0, 2'b00, 2'b10, 2'b00, 3'b010, 2'b00, 0));
  endtask

  initial begin
    F_RDY   = mk(1,0,0,1,1,0, 2'b00, 2'b00, 2'b10, 3'b000, 2'b10, 0);
    F_WAIT  = mk(1,0,0,0,0,0, 2'b00, 2'b00, 2'b10, 3'b000, 2'b10, 0);
    DEC     = mk(0,0,0,0,0,0, 2'b10, 2'b01, 2'b01, 3'b000, 2'b00, 0);
    DEC_ILL = mk(0,0,0,0,0,0, 2'b10, 2'b01, 2'b01, 3'b000, 2'b00, 1);
    ALUWB   = mk(0,0,0,0,0,1, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 0);

    rst_n = 1'b0;
    bus.instr_32  = 32'h0;
    bus.ZF        = 1'b0;
    bus.SF        = 1'b0;
    bus.mem_ready = 1'b1;
    #12;
    check("reset_outs", {14'b0, outs}, 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Fetch stalled three cycles, then completes
    bus.mem_ready = 1'b0;
    for (int i = 0; i < 3; i++) step("fetch_wait", F_WAIT);
    fetch("lw_fetch", 32'h00412083);
    step("lw_dec", DEC);
    step("lw_adr", mk(0,0,0,0,0,0, 2'b00, 2'b10, 2'b01, 3'b000, 2'b00, 0));
    step("lw_rd",  mk(1,0,1,0,0,0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 0));
    step("lw_wb",  mk(0,0,0,0,0,1, 2'b00, 2'b00, 2'b00, 3'b000, 2'b01, 0));

    exec_rr("sub",  32'h40208033, 1'b0, 3'b010);
    exec_rr("addi", 32'h40008093, 1'b1, 3'b000);
    exec_rr("slli", 32'h00109093, 1'b1, 3'b001);
    exec_rr("and",  32'h0020F033, 1'b0, 3'b111);
    exec_rr("xor",  32'h0020C033, 1'b0, 3'b100);

    fetch("sw_fetch", 32'h00112223);
    step("sw_dec", DEC);
    step("sw_adr", mk(0,0,0,0,0,0, 2'b01, 2'b10, 2'b01, 3'b000, 2'b00, 0));
    step("sw_wr",  mk(1,1,1,0,0,0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 0));

    branch("bne_nz",   32'h00209063, 1'b0, 1'b0, 1'b1);
    branch("bne_z",    32'h00209063, 1'b1, 1'b0, 1'b0);
    branch("blt_neg",  32'h0020C063, 1'b0, 1'b1, 1'b1);
    branch("f3_010",   32'h0020A063, 1'b1, 1'b1, 1'b0);

    fetch("ill_fetch", 32'h0000007F);
    step("ill_dec", DEC_ILL);
`ifdef RISC_PERF_CNT_EN
    check("instret_after_illegal", instret_32, 32'd11);
`endif

    // Reset asserted while a load waits on memory
    fetch("rst_lw_fetch", 32'h00412083);
    step("rst_lw_dec", DEC);
    step("rst_lw_adr", mk(0,0,0,0,0,0, 2'b00, 2'b10, 2'b01, 3'b000, 2'b00, 0));
    bus.mem_ready = 1'b0;
    @(negedge clk);
    check("rst_lw_rd", {14'b0, outs}, {14'b0, mk(1,0,1,0,0,0, 2'b00, 2'b00, 2'b00, 3'b000, 2'b00, 0)});
    #2;
    rst_n = 1'b0;
    #1;
    check("rst_async", {14'b0, outs}, 32'h0);
    @(negedge clk);
    check("rst_held", {14'b0, outs}, 32'h0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    step("rst_release", F_WAIT);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
